// File: rtl/dreg_shifter.sv
// dreg_shifter: WIDTH-bit parallel-load register with start/busy/done serialiser
//
// Ports:
//   clk    rising-edge clock
//   arst   asynchronous active-high reset (clears register, FSM, counter, done)
//   load   parallel load request; wins over start and aborts a running shift
//   din    parallel load data
//   start  begin serialising the current contents (accepted only in IDLE)
//   sin    serial fill bit shifted into the vacated end
//   dout   current register contents
//   sout   outgoing bit: q[0] when LSB_FIRST, else q[WIDTH-1]
//   busy   high while shifting
//   done   one-cycle pulse after the final shift
//
// Build option: define DREG_SHIFTER_ROTATE_EN to refill with the outgoing bit
// (rotate) instead of sin, so a full serialisation leaves q unchanged.
module dreg_shifter #(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             start,
    input  logic             sin,
    output logic [WIDTH-1:0] dout,
    output logic             sout,
    output logic             busy,
    output logic             done
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state, state_nx;
    logic [CW-1:0]    cnt, cnt_nx;
    logic [WIDTH-1:0] q, q_nx, shifted;
    logic             done_nx, fill, last;

`ifdef DREG_SHIFTER_ROTATE_EN
    logic unused_sin;
    assign unused_sin = sin;
    assign fill       = sout;
`else
    assign fill = sin;
`endif

    assign shifted = LSB_FIRST ? {fill, q[WIDTH-1:1]} : {q[WIDTH-2:0], fill};
    // cnt holds the number of shifts already done; the WIDTH-th shift ends the run
    assign last    = cnt == CW'(WIDTH - 1);

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state <= IDLE;
            cnt   <= '0;
            q     <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            q     <= q_nx;
            done  <= done_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        q_nx     = q;
        done_nx  = 1'b0;
        if (load) begin
            q_nx     = din;
            state_nx = IDLE;
            cnt_nx   = '0;
        end else if (state == IDLE) begin
            state_nx = start ? SHIFT : IDLE;
            cnt_nx   = start ? '0 : cnt;
        end else begin
            q_nx     = shifted;
            cnt_nx   = cnt + 1'b1;
            state_nx = last ? IDLE : SHIFT;
            done_nx  = last;
        end
    end

    always_comb begin
        dout = q;
        sout = LSB_FIRST ? q[0] : q[WIDTH-1];
        busy = state == SHIFT;
    end

endmodule

// File: tb/tb_dreg_shifter.sv
// tb_dreg_shifter: directed table-driven check of LSB-first and MSB-first dreg_shifter
module tb_dreg_shifter;
`ifdef DREG_SHIFTER_ROTATE_EN
    localparam bit ROT = 1'b1;
`else
    localparam bit ROT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       arst, load, start, sin;
    logic [7:0] din;
    logic [7:0] l_dout, m_dout;
    logic       l_sout, m_sout, l_busy, m_busy, l_done, m_done;
    int         tests = 0;
    int         fails = 0;

    always #5 clk = ~clk;

    dreg_shifter #(.WIDTH(8), .LSB_FIRST(1'b1)) u_lsb (
        .clk(clk), .arst(arst), .load(load), .din(din), .start(start), .sin(sin),
        .dout(l_dout), .sout(l_sout), .busy(l_busy), .done(l_done)
    );

    dreg_shifter #(.WIDTH(8), .LSB_FIRST(1'b0)) u_msb (
        .clk(clk), .arst(arst), .load(load), .din(din), .start(start), .sin(sin),
        .dout(m_dout), .sout(m_sout), .busy(m_busy), .done(m_done)
    );

    typedef struct {
        logic       ld;
        logic [7:0] din;
        logic       st;
        logic       si;
        logic [7:0] l_dout;
        logic [7:0] m_dout;
        logic       busy;
        logic       done;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [7:0] pick(logic [7:0] rot_val, logic [7:0] fill_val);
        return ROT ? rot_val : fill_val;
    endfunction

    function automatic void add(logic ld, logic [7:0] d, logic st, logic si,
                                logic [7:0] ld_exp, logic [7:0] md_exp, logic b, logic dn);
        vec_t v;
        v.ld = ld; v.din = d; v.st = st; v.si = si;
        v.l_dout = ld_exp; v.m_dout = md_exp; v.busy = b; v.done = dn;
        vecs.push_back(v);
    endfunction

    task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(string tag, logic [7:0] ld_exp, logic [7:0] md_exp, logic b, logic dn);
        chk({tag, " l_dout"}, l_dout, ld_exp);
        chk({tag, " m_dout"}, m_dout, md_exp);
        chk({tag, " l_sout"}, {7'd0, l_sout}, {7'd0, ld_exp[0]});
        chk({tag, " m_sout"}, {7'd0, m_sout}, {7'd0, md_exp[7]});
        chk({tag, " l_busy"}, {7'd0, l_busy}, {7'd0, b});
        chk({tag, " m_busy"}, {7'd0, m_busy}, {7'd0, b});
        chk({tag, " l_done"}, {7'd0, l_done}, {7'd0, dn});
        chk({tag, " m_done"}, {7'd0, m_done}, {7'd0, dn});
    endtask

    task automatic run_rows(int lo, int hi);
        for (int i = lo; i <= hi; i++) begin
            load = vecs[i].ld; din = vecs[i].din; start = vecs[i].st; sin = vecs[i].si;
            @(posedge clk);
            #1;
            chk_all($sformatf("row%0d", i), vecs[i].l_dout, vecs[i].m_dout, vecs[i].busy, vecs[i].done);
        end
        load = 1'b0; start = 1'b0; sin = 1'b0;
    endtask

    initial begin
        // serialise A5 with sin=0
        add(1, 8'hA5, 0, 0, 8'hA5, 8'hA5, 0, 0);
        add(0, 8'h00, 1, 0, 8'hA5, 8'hA5, 1, 0);
        add(0, 8'h00, 0, 0, pick(8'hD2, 8'h52), pick(8'h4B, 8'h4A), 1, 0);
        add(0, 8'h00, 0, 0, pick(8'h69, 8'h29), pick(8'h96, 8'h94), 1, 0);
        add(0, 8'h00, 0, 0, pick(8'hB4, 8'h14), pick(8'h2D, 8'h28), 1, 0);
        add(0, 8'h00, 0, 0, pick(8'h5A, 8'h0A), pick(8'h5A, 8'h50), 1, 0);
        add(0, 8'h00, 0, 0, pick(8'h2D, 8'h05), pick(8'hB4, 8'hA0), 1, 0);
        add(0, 8'h00, 0, 0, pick(8'h96, 8'h02), pick(8'h69, 8'h40), 1, 0);
        add(0, 8'h00, 0, 0, pick(8'h4B, 8'h01), pick(8'hD2, 8'h80), 1, 0);
        add(0, 8'h00, 0, 0, pick(8'hA5, 8'h00), pick(8'hA5, 8'h00), 0, 1);
        add(0, 8'h00, 0, 0, pick(8'hA5, 8'h00), pick(8'hA5, 8'h00), 0, 0);
        // sin=1, start held high through the busy window
        add(1, 8'hA5, 0, 1, 8'hA5, 8'hA5, 0, 0);
        add(0, 8'h00, 1, 1, 8'hA5, 8'hA5, 1, 0);
        add(0, 8'h00, 1, 1, pick(8'hD2, 8'hD2), pick(8'h4B, 8'h4B), 1, 0);
        add(0, 8'h00, 1, 1, pick(8'h69, 8'hE9), pick(8'h96, 8'h97), 1, 0);
        add(0, 8'h00, 1, 1, pick(8'hB4, 8'hF4), pick(8'h2D, 8'h2F), 1, 0);
        add(0, 8'h00, 1, 1, pick(8'h5A, 8'hFA), pick(8'h5A, 8'h5F), 1, 0);
        add(0, 8'h00, 1, 1, pick(8'h2D, 8'hFD), pick(8'hB4, 8'hBF), 1, 0);
        add(0, 8'h00, 1, 1, pick(8'h96, 8'hFE), pick(8'h69, 8'h7F), 1, 0);
        add(0, 8'h00, 1, 1, pick(8'h4B, 8'hFF), pick(8'hD2, 8'hFF), 1, 0);
        add(0, 8'h00, 1, 1, pick(8'hA5, 8'hFF), pick(8'hA5, 8'hFF), 0, 1);
        // start in the done cycle is accepted, then a load aborts without done
        add(0, 8'h00, 1, 1, pick(8'hA5, 8'hFF), pick(8'hA5, 8'hFF), 1, 0);
        add(1, 8'h3C, 0, 0, 8'h3C, 8'h3C, 0, 0);
        // serialise 3C with sin toggling
        add(0, 8'h00, 1, 0, 8'h3C, 8'h3C, 1, 0);
        add(0, 8'h00, 0, 1, pick(8'h1E, 8'h9E), pick(8'h78, 8'h79), 1, 0);
        add(0, 8'h00, 0, 0, pick(8'h0F, 8'h4F), pick(8'hF0, 8'hF2), 1, 0);
        add(0, 8'h00, 0, 1, pick(8'h87, 8'hA7), pick(8'hE1, 8'hE5), 1, 0);
        add(0, 8'h00, 0, 0, pick(8'hC3, 8'h53), pick(8'hC3, 8'hCA), 1, 0);
        add(0, 8'h00, 0, 1, pick(8'hE1, 8'hA9), pick(8'h87, 8'h95), 1, 0);
        add(0, 8'h00, 0, 0, pick(8'hF0, 8'h54), pick(8'h0F, 8'h2A), 1, 0);
        add(0, 8'h00, 0, 1, pick(8'h78, 8'hAA), pick(8'h1E, 8'h55), 1, 0);
        add(0, 8'h00, 0, 0, pick(8'h3C, 8'h55), pick(8'h3C, 8'hAA), 0, 1);
        // load beats start in IDLE
        add(1, 8'h81, 1, 0, 8'h81, 8'h81, 0, 0);
        add(0, 8'h00, 0, 0, 8'h81, 8'h81, 0, 0);
        // abort by load in busy cycle 3
        add(0, 8'h00, 1, 0, 8'h81, 8'h81, 1, 0);
        add(0, 8'h00, 0, 0, pick(8'hC0, 8'h40), pick(8'h03, 8'h02), 1, 0);
        add(0, 8'h00, 0, 0, pick(8'h60, 8'h20), pick(8'h06, 8'h04), 1, 0);
        add(1, 8'h5A, 0, 0, 8'h5A, 8'h5A, 0, 0);
        add(0, 8'h00, 0, 0, 8'h5A, 8'h5A, 0, 0);

        // reset held with load/start active
        arst = 1'b1; load = 1'b1; din = 8'hFF; start = 1'b1; sin = 1'b1;
        #1;
        chk_all("rst_t0", 8'h00, 8'h00, 0, 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk_all($sformatf("rst_clk%0d", i), 8'h00, 8'h00, 0, 0);
        end
        arst = 1'b0; load = 1'b0; start = 1'b0; sin = 1'b0; din = 8'h00;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            chk_all($sformatf("post_rst%0d", i), 8'h00, 8'h00, 0, 0);
        end

        run_rows(0, vecs.size() - 1);

        // reset between edges during busy cycle 4
        run_rows(0, 1);
        repeat (3) @(posedge clk);
        #1;
        chk_all("mid_busy4", pick(8'hB4, 8'h14), pick(8'h2D, 8'h28), 1, 0);
        #2 arst = 1'b1;
        #1;
        chk_all("mid_rst_async", 8'h00, 8'h00, 0, 0);
        @(posedge clk);
        #1;
        chk_all("mid_rst_hold", 8'h00, 8'h00, 0, 0);
        arst = 1'b0;
        run_rows(0, 10);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
